// File: rtl/fp32_add.sv
// fp32_add: binary32 adder with selectable rounding, one-cycle registered result
module fp32_add (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IN1,
  input  logic [31:0] IN2,
  input  logic [2:0]  ROUND_TYPE,
  output logic [31:0] OUT
);
  logic [31:0] out_d, out_q;
  logic [31:0] big, sml, pk;
  logic [7:0]  el, es, d, sh;
  logic [23:0] ml, ms;
  logic [50:0] al;
  logic [26:0] ms27, m27;
  logic [27:0] sum;
  logic [8:0]  en;
  logic [4:0]  lz;
  logic [2:0]  rm;
  logic        sl, sub, inc, inx, ovf, inf_r, nan1, nan2, inf1, inf2;
  // swap/align/add/normalize/round datapath plus special-value override
  always_comb begin
    rm    = ROUND_TYPE > 3'd4 ? 3'd0 : ROUND_TYPE;
    nan1  = &IN1[30:23] & |IN1[22:0];
    nan2  = &IN2[30:23] & |IN2[22:0];
    inf1  = &IN1[30:23] & ~|IN1[22:0];
    inf2  = &IN2[30:23] & ~|IN2[22:0];
    big   = IN1[30:0] >= IN2[30:0] ? IN1 : IN2;
    sml   = IN1[30:0] >= IN2[30:0] ? IN2 : IN1;
    sl    = big[31];
    sub   = big[31] ^ sml[31];
    el    = big[30:23] == 8'd0 ? 8'd1 : big[30:23];
    es    = sml[30:23] == 8'd0 ? 8'd1 : sml[30:23];
    ml    = {|big[30:23], big[22:0]};
    ms    = {|sml[30:23], sml[22:0]};
    d     = el - es;
    al    = {ms, 27'b0} >> (d > 8'd27 ? 8'd27 : d);
    ms27  = {al[50:25], |al[24:0]};
    sum   = sub ? {1'b0, ml, 3'b0} - {1'b0, ms27} : {1'b0, ml, 3'b0} + {1'b0, ms27};
    lz    = 5'd27;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
    sh    = ({3'b0, lz} < el - 8'd1) ? {3'b0, lz} : el - 8'd1;
    m27   = sum[27] ? {sum[27:2], |sum[1:0]} : sum[26:0] << sh;
    en    = sum[27] ? {1'b0, el} + 9'd1 : (m27[26] ? {1'b0, el} - {1'b0, sh} : 9'd0);
    inx   = |m27[2:0];
    inc   = rm == 3'd0 ? m27[2] & (m27[1] | m27[0] | m27[3])
          : rm == 3'd1 ? 1'b0
          : rm == 3'd2 ? sl & inx
          : rm == 3'd3 ? ~sl & inx
          : m27[2];
    pk    = {en, m27[25:3]} + 32'(inc);
    ovf   = pk[31:23] >= 9'd255;
    inf_r = rm == 3'd0 || rm == 3'd4 || (rm == 3'd2 && sl) || (rm == 3'd3 && !sl);
    out_d = (nan1 | nan2 | (inf1 & inf2 & (IN1[31] ^ IN2[31]))) ? 32'h7FC00000
          : inf1 ? IN1
          : inf2 ? IN2
          : ~|sum ? {sub ? rm == 3'd2 : sl, 31'b0}
          : ovf ? {sl, inf_r ? 31'h7F800000 : 31'h7F7FFFFF}
          : {sl, pk[30:0]};
  end
  // result register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= 32'h0;
    else        out_q <= out_d;
  end
  assign OUT = out_q;
endmodule

// File: tb/tb_fp32_add.sv
// tb_fp32_add: directed and random checks of fp32_add against an exact-arithmetic model
module tb_fp32_add;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IN1, IN2, OUT;
  logic [2:0]  ROUND_TYPE;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] prev_exp;

  fp32_add dut (.clk(clk), .rst_n(rst_n), .IN1(IN1), .IN2(IN2), .ROUND_TYPE(ROUND_TYPE), .OUT(OUT));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (IN1=%h IN2=%h rm=%0d)", tag, got, exp, IN1, IN2, ROUND_TYPE);
    end
  endtask

  // Exact sum in units of 2^-149, then rounded once to binary32.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rt);
    logic [299:0] x, y, mag, q, rem, half;
    logic [2:0]   rm;
    logic         s, inc, nana, nanb, infa, infb;
    int           ea, eb, p, sh, e;
    rm   = rt > 3'd4 ? 3'd0 : rt;
    nana = a[30:23] == 8'hFF && a[22:0] != 0;
    nanb = b[30:23] == 8'hFF && b[22:0] != 0;
    infa = a[30:23] == 8'hFF && a[22:0] == 0;
    infb = b[30:23] == 8'hFF && b[22:0] == 0;
    if (nana || nanb) return 32'h7FC00000;
    if (infa && infb && a[31] != b[31]) return 32'h7FC00000;
    if (infa) return a;
    if (infb) return b;
    ea  = a[30:23] == 0 ? 1 : int'(a[30:23]);
    eb  = b[30:23] == 0 ? 1 : int'(b[30:23]);
    x   = 300'({a[30:23] != 0, a[22:0]}) << (ea - 1);
    y   = 300'({b[30:23] != 0, b[22:0]}) << (eb - 1);
    if (a[31] == b[31]) begin mag = x + y; s = a[31]; end
    else if (x >= y)    begin mag = x - y; s = a[31]; end
    else                begin mag = y - x; s = b[31]; end
    if (mag == 0) return {(a[31] == b[31]) ? a[31] : (rm == 3'd2), 31'b0};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p <= 23) return {s, mag[30:0]};
    sh   = p - 23;
    q    = mag >> sh;
    rem  = mag - (q << sh);
    half = 300'd1 << (sh - 1);
    case (rm)
      3'd0:    inc = rem > half || (rem == half && q[0]);
      3'd1:    inc = 1'b0;
      3'd2:    inc = s && rem != 0;
      3'd3:    inc = !s && rem != 0;
      default: inc = rem >= half;
    endcase
    q = q + 300'(inc);
    if (q[24]) begin q = q >> 1; sh++; end
    e = sh + 1;
    if (e >= 255)
      return (rm == 3'd0 || rm == 3'd4 || (rm == 3'd2 && s) || (rm == 3'd3 && !s)) ? {s, 31'h7F800000} : {s, 31'h7F7FFFFF};
    return {s, 8'(e), q[22:0]};
  endfunction

  // Apply one vector at the falling edge: check the prior result, then that OUT holds after the input change.
  task automatic drive(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm, input logic [31:0] exp);
    @(negedge clk);
    chk("pipe", OUT, prev_exp);
    IN1 = a; IN2 = b; ROUND_TYPE = rm;
    #1 chk("hold", OUT, prev_exp);
    prev_exp = exp;
    if (tag != "") begin
      @(negedge clk);
      chk(tag, OUT, exp);
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0:       r[30:0] = 31'h0;
      1:       r[30:0] = 31'h7F800000;
      2:       r[30:23] = 8'hFF;
      3:       r[30:23] = 8'h00;
      4:       r[30:23] = 8'(254 - $urandom_range(0, 2));
      5:       r[30:23] = 8'(120 + $urandom_range(0, 15));
      default: ;
    endcase
    return r;
  endfunction

  logic [98:0] dv [34] = '{
    {32'h3FC00000, 32'h3FC00000, 3'd0, 32'h40400000},
    {32'h40000000, 32'h3F800000, 3'd0, 32'h40400000},
    {32'h40000000, 32'h40000000, 3'd0, 32'h40800000},
    {32'h3ED00000, 32'h40200000, 3'd0, 32'h403A0000},
    {32'h46900000, 32'h48700000, 3'd0, 32'h48810000},
    {32'h40000000, 32'hBF800000, 3'd0, 32'h3F800000},
    {32'hBEB00000, 32'h40000000, 3'd0, 32'h3FD40000},
    {32'hBDF00000, 32'h3F900000, 3'd0, 32'h3F810000},
    {32'hBFE00000, 32'h3FF00000, 3'd0, 32'h3E000000},
    {32'hBF700000, 32'h3F800000, 3'd0, 32'h3D800000},
    {32'hBF100000, 32'h3FD00000, 3'd0, 32'h3F880000},
    {32'hBFA00000, 32'h3F800000, 3'd0, 32'hBE800000},
    {32'hBF91EB85, 32'h75CABCBD, 3'd0, 32'h75CABCBD},
    {32'h3F800000, 32'hBF800000, 3'd0, 32'h00000000},
    {32'h3F800000, 32'hBF800000, 3'd2, 32'h80000000},
    {32'h7F800000, 32'hFF800000, 3'd0, 32'h7FC00000},
    {32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000},
    {32'h7F800000, 32'h3F800000, 3'd0, 32'h7F800000},
    {32'h00000001, 32'h00000001, 3'd0, 32'h00000002},
    {32'h7F7FFFFF, 32'h7F7FFFFF, 3'd0, 32'h7F800000},
    {32'h7F7FFFFF, 32'h7F7FFFFF, 3'd1, 32'h7F7FFFFF},
    {32'h3F800000, 32'h33800000, 3'd0, 32'h3F800000},
    {32'h3F800000, 32'h33800000, 3'd3, 32'h3F800001},
    {32'h3F800000, 32'h33800000, 3'd4, 32'h3F800001},
    {32'h3F800000, 32'h33800000, 3'd2, 32'h3F800000},
    {32'h00000000, 32'h80000000, 3'd0, 32'h00000000},
    {32'h00000000, 32'h80000000, 3'd2, 32'h80000000},
    {32'h80000000, 32'h80000000, 3'd0, 32'h80000000},
    {32'h00000000, 32'h00000001, 3'd0, 32'h00000001},
    {32'h7F7FFFFF, 32'h7F7FFFFF, 3'd2, 32'h7F7FFFFF},
    {32'hFF7FFFFF, 32'hFF7FFFFF, 3'd2, 32'hFF800000},
    {32'hFF7FFFFF, 32'hFF7FFFFF, 3'd3, 32'hFF7FFFFF},
    {32'h7F7FFFFF, 32'h7F7FFFFF, 3'd3, 32'h7F800000},
    {32'h3FC00000, 32'h3FC00000, 3'd6, 32'h40400000}
  };

  initial begin
    logic [31:0] a, b;
    logic [2:0]  rm;
    rst_n = 1'b0; IN1 = 32'h3FC00000; IN2 = 32'h3FC00000; ROUND_TYPE = 3'd0;
    repeat (2) @(negedge clk);
    chk("reset", OUT, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_edge", OUT, 32'h40400000);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", OUT, 32'h0);
    @(negedge clk);
    chk("reset_hold", OUT, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset", OUT, 32'h40400000);
    prev_exp = 32'h40400000;
    foreach (dv[i]) begin
      drive($sformatf("vec%0d", i), dv[i][98:67], dv[i][66:35], dv[i][34:32], dv[i][31:0]);
      drive($sformatf("vec%0d_swap", i), dv[i][66:35], dv[i][98:67], dv[i][34:32], dv[i][31:0]);
    end
    foreach (dv[i]) drive("", dv[i][98:67], dv[i][66:35], dv[i][34:32], dv[i][31:0]);
    for (int n = 0; n < 3000; n++) begin
      a  = rand_op();
      rm = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       b = a ^ 32'h80000000;
        1:       b = {1'($urandom), 8'(a[30:23] + 8'($urandom_range(0, 4)) - 8'd2), 23'($urandom)};
        default: b = rand_op();
      endcase
      drive("", a, b, rm, ref_add(a, b, rm));
      drive("", b, a, rm, ref_add(a, b, rm));
    end
    @(negedge clk);
    chk("last", OUT, prev_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fp32_add.md
Name: fp32_add

Overview:
- Single-precision IEEE 754 binary32 adder with a selectable rounding mode.
- Computes OUT = IN1 + IN2 with full special-value, subnormal and rounding handling.
- Combinational datapath, registered output stage; fully pipelined, one result per clock.
- Basic arithmetic building block, used standalone and as the reference for the fused datapaths.

Parameters:
- None. Format is fixed to binary32: 1 sign bit, 8 exponent bits, 23 fraction bits, bias 127.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- IN1  input  32  operand A, binary32
- IN2  input  32  operand B, binary32
- ROUND_TYPE  input  3  rounding mode: 0 = RTNE (`ROUND_RTNE), 1 = RTZ, 2 = RDN, 3 = RUP, 4 = RMM; 5-7 treated as RTNE
- OUT  output  32  registered sum, binary32

Behaviour:
- Reset: rst_n low asynchronously forces OUT = 32'h00000000. OUT holds 0 until the first rising clk edge after rst_n deasserts.
- Latency: exactly 1 cycle.
  - The sum of IN1/IN2/ROUND_TYPE sampled at rising edge N appears on OUT after edge N.
  - No handshake; a new operation is accepted every cycle; OUT holds between edges.
- Operand handling:
  - Operands are commutative: swapping IN1/IN2 gives a bit-identical OUT.
  - Subnormal inputs are fully supported (implicit bit 0, exponent treated as 1). No flush-to-zero.
- Datapath:
  - Swap so the larger magnitude is first; exponent difference d.
  - Align the smaller significand right by d, keeping guard, round and sticky bits. The sticky bit is the OR of all bits shifted out. For d > 26 the smaller operand contributes sticky only.
  - Effective add when signs match, else subtract the smaller from the larger. The result sign is the sign of the larger-magnitude operand.
  - Normalize:
    - On carry-out, shift right 1 and increment the exponent.
    - On cancellation, left-shift by the leading-zero count, limited so the exponent does not go below 1 (subnormal result).
  - Round using guard/round/sticky per ROUND_TYPE:
    - RTNE: round to nearest, ties to even.
    - RTZ: truncate.
    - RDN: toward negative infinity.
    - RUP: toward positive infinity.
    - RMM: round to nearest, ties away from zero.
    - A mantissa overflow from rounding renormalizes and increments the exponent.
  - Overflow (exponent ≥ 255 after rounding):
    - RTNE and RMM give ±Inf.
    - RTZ gives ±7F7FFFFF.
    - RDN gives +7F7FFFFF for positive results and -Inf for negative results.
    - RUP gives +Inf for positive results and FF7FFFFF for negative results.
- Special values, highest priority first:
  - Either operand NaN gives canonical qNaN 7FC00000.
  - +Inf + -Inf gives 7FC00000.
  - Otherwise Inf + anything gives that Inf.
  - Zero + x gives x, exact, including subnormal x.
  - +0 + -0 gives +0, except under RDN, which gives -0 (80000000).
  - -0 + -0 gives -0.
- Exact cancellation: x + (-x) gives +0 (00000000), except under RDN, which gives 80000000.
- Huge exponent gap: a tiny addend vs a large one leaves the large one unchanged under RTNE (e.g. BF91EB85 + 75CABCBD gives 75CABCBD).
- No exception flag outputs.

Test Plan:
- Reset:
  - Stimulus: assert rst_n = 0 mid-cycle with IN1 = IN2 = 3FC00000.
  - Required: OUT = 00000000 immediately and held while rst_n is low.
  - Stimulus: release rst_n, then apply one edge.
  - Required: OUT = 40400000.
- Normal adds, RTNE, each checked one cycle after apply and with operands swapped:
  - 3FC00000 + 3FC00000 -> 40400000
  - 40000000 + 3F800000 -> 40400000
  - 40000000 + 40000000 -> 40800000
  - 3ED00000 + 40200000 -> 403A0000
  - 46900000 + 48700000 -> 48810000
- Subtraction and cancellation, RTNE, both operand orders:
  - 40000000 + BF800000 -> 3F800000
  - BEB00000 + 40000000 -> 3FD40000
  - BDF00000 + 3F900000 -> 3F810000
  - BFE00000 + 3FF00000 -> 3E000000
  - BF700000 + 3F800000 -> 3D800000
  - BF100000 + 3FD00000 -> 3F880000
  - BFA00000 + 3F800000 -> BE800000
- Large exponent gap and exact zero:
  - BF91EB85 + 75CABCBD -> 75CABCBD
  - 3F800000 + BF800000 -> 00000000 under RTNE
  - 3F800000 + BF800000 -> 80000000 under RDN
- Specials:
  - 7F800000 + FF800000 -> 7FC00000
  - 7FC00001 + 3F800000 -> 7FC00000
  - 7F800000 + 3F800000 -> 7F800000
  - 00000001 + 00000001 -> 00000002 (subnormal)
- Rounding and overflow:
  - 7F7FFFFF + 7F7FFFFF -> 7F800000 (RTNE), 7F7FFFFF (RTZ)
  - 3F800000 + 33800000 -> 3F800000 (RTNE tie-to-even), 3F800001 (RUP, RMM)
  - Back-to-back vectors on consecutive cycles each emerge exactly one cycle later.
